// File: rtl/irq_encoder8_3_pkg.sv
// -----------------------------------------------------------------------------
// irq_encoder8_3_pkg
// Shared constants and types for the interrupt request encoder:
//   N_REQ   : number of request lines (fixed at 8)
//   IDX_W   : width of the encoded index (log2 of N_REQ)
//   state_t : handshake FSM state encoding (ST_IDLE / ST_VALID)
// -----------------------------------------------------------------------------
package irq_encoder8_3_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

endpackage : irq_encoder8_3_pkg

// File: rtl/irq_encoder8_3_dec.sv
// -----------------------------------------------------------------------------
// irq_encoder8_3_dec
// 3-to-8 decoder with enable. Produces the one-hot of idx when en=1, all zeros
// otherwise. The encoder uses it to build the pending-clear mask from the
// currently presented index.
// Ports:
//   idx    in  3  index to decode
//   en     in  1  decode enable
//   onehot out 8  one-hot result (zero when en=0)
// -----------------------------------------------------------------------------
module irq_encoder8_3_dec
  import irq_encoder8_3_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign onehot[gi] = en && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule : irq_encoder8_3_dec

// File: rtl/irq_encoder8_3.sv
// -----------------------------------------------------------------------------
// irq_encoder8_3
// Sequential 8-to-3 priority encoder with rising-edge request capture and a
// valid/ack handshake. Rising edges on req_in set bits in a pending register;
// the highest-priority unmasked pending bit is latched into enc_idx and held,
// with enc_valid=1, until the consumer asserts enc_ack. The ack clears that
// pending bit and the FSM returns to IDLE for one cycle before the next pick.
// Parameters:
//   HIGH_FIRST : 1 = bit 7 has highest priority, 0 = bit 0 highest
//   N_REQ      : number of request lines (must be 8)
// Ports:
//   clk         in  1  rising-edge clock
//   rst         in  1  synchronous active-high reset
//   req_in      in  8  request levels (rising edges are captured)
//   mask_in     in  8  1 = bit ignored for selection (still captured)
//   enc_ack     in  1  consumer accepts enc_idx (only honoured while valid)
//   enc_valid   out 1  enc_idx holds a selection
//   enc_idx     out 3  selected request index
//   pending_out out 8  pending register
//   any_pending out 1  |(pending & ~mask_in)
// -----------------------------------------------------------------------------
module irq_encoder8_3 #(
  parameter bit HIGH_FIRST = 1'b1,
  parameter int N_REQ      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask_in,
  input  logic             enc_ack,
  output logic             enc_valid,
  output logic [2:0]       enc_idx,
  output logic [N_REQ-1:0] pending_out,
  output logic             any_pending
);

  import irq_encoder8_3_pkg::*;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   req_q_reg;
  logic [N_REQ-1:0]   pending_reg, pending_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [N_REQ-1:0]   rise;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   clr;
  logic               clr_en;

  // Priority encode: the later assignment in the scan wins, so scanning
  // upward favours high bits and scanning downward favours low bits.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < N_REQ; i++)
        if (v[i]) r = IDX_W'(i);
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--)
        if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign rise     = req_in & ~req_q_reg;
  assign eligible = pending_reg & ~mask_in;
  assign clr_en   = (state_reg == ST_VALID) && enc_ack;

  irq_encoder8_3_dec u_clr_dec (
    .idx    (idx_reg),
    .en     (clr_en),
    .onehot (clr)
  );

  // A new edge on the bit being acknowledged keeps it pending (set wins).
  assign pending_next = (pending_reg & ~clr) | rise;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|eligible) begin
          idx_next   = prio_enc(eligible);
          state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        // idx is frozen here regardless of mask or pending changes.
        if (enc_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      req_q_reg   <= '0;
      pending_reg <= '0;
      idx_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      req_q_reg   <= req_in;
      pending_reg <= pending_next;
      idx_reg     <= idx_next;
    end
  end

  assign enc_valid   = (state_reg == ST_VALID);
  assign enc_idx     = idx_reg;
  assign pending_out = pending_reg;
  assign any_pending = |eligible;

endmodule : irq_encoder8_3

// File: tb/tb_irq_encoder8_3.sv
module tb_irq_encoder8_3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in, mask_in;
  logic       enc_ack;
  logic       enc_valid, any_pending;
  logic [2:0] enc_idx;
  logic [7:0] pending_out;

  // Low-first instance with its own request/ack lines.
  logic [7:0] req_lo, mask_lo;
  logic       ack_lo;
  logic       valid_lo, any_lo;
  logic [2:0] idx_lo;
  logic [7:0] pend_lo;

  int checks = 0;
  int errors = 0;
  int q_hi[$];
  int q_lo[$];

  always #5 clk = ~clk;

  irq_encoder8_3 #(.HIGH_FIRST(1'b1), .N_REQ(8)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_in(mask_in), .enc_ack(enc_ack),
    .enc_valid(enc_valid), .enc_idx(enc_idx), .pending_out(pending_out),
    .any_pending(any_pending)
  );

  irq_encoder8_3 #(.HIGH_FIRST(1'b0), .N_REQ(8)) dut_lo (
    .clk(clk), .rst(rst), .req_in(req_lo), .mask_in(mask_lo), .enc_ack(ack_lo),
    .enc_valid(valid_lo), .enc_idx(idx_lo), .pending_out(pend_lo),
    .any_pending(any_lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for the selected instance to present a valid index.
  task automatic wait_valid(input bit lo);
    int n = 0;
    while (!(lo ? valid_lo : enc_valid) && n < 20) begin
      step(1);
      n++;
    end
    if (!(lo ? valid_lo : enc_valid)) begin
      checks++;
      errors++;
      $display("FAIL wait_valid(lo=%0d): enc_valid 0 expected 1 within 20 cycles", lo);
    end
  endtask

  // Wait for a presentation, ack it for one cycle, check the bubble.
  task automatic serve(input bit lo);
    wait_valid(lo);
    if (lo) ack_lo = 1'b1; else enc_ack = 1'b1;
    step(1);
    ack_lo  = 1'b0;
    enc_ack = 1'b0;
    chk(lo ? "bubble_lo" : "bubble_hi", lo ? valid_lo : enc_valid, 0);
  endtask

  // Monitors: each new presentation pops the scoreboard; while held, the
  // index must stay equal to the popped value.
  initial begin : mon_hi
    bit prev = 1'b0;
    int cur = 0;
    forever begin
      @(negedge clk);
      if (enc_valid && !prev) begin
        if (q_hi.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_hi: unexpected presentation idx %0d", enc_idx);
        end else begin
          cur = q_hi.pop_front();
          chk("mon_hi_idx", 32'(enc_idx), 32'(cur));
        end
      end else if (enc_valid && prev) begin
        checks++;
        if (32'(enc_idx) != 32'(cur)) begin
          errors++;
          $display("FAIL mon_hi_hold: got %0d expected %0d", enc_idx, cur);
        end
      end
      prev = enc_valid;
    end
  end

  initial begin : mon_lo
    bit prev = 1'b0;
    int cur = 0;
    forever begin
      @(negedge clk);
      if (valid_lo && !prev) begin
        if (q_lo.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_lo: unexpected presentation idx %0d", idx_lo);
        end else begin
          cur = q_lo.pop_front();
          chk("mon_lo_idx", 32'(idx_lo), 32'(cur));
        end
      end
      prev = valid_lo;
    end
  end

  initial begin
    rst = 1'b1; req_in = 8'h00; mask_in = 8'h00; enc_ack = 1'b0;
    req_lo = 8'h00; mask_lo = 8'h00; ack_lo = 1'b0;
    step(3);
    chk("rst_valid", enc_valid, 0);
    chk("rst_idx", enc_idx, 0);
    chk("rst_pending", pending_out, 8'h00);

    // Line held high through reset is captured once after release.
    req_in = 8'h10;
    step(3);
    rst = 1'b0;
    q_hi.push_back(4);
    step(1);
    chk("held_pending", pending_out, 8'h10);
    chk("held_valid_early", enc_valid, 0);
    step(1);
    chk("held_valid", enc_valid, 1);
    chk("held_idx", enc_idx, 4);
    enc_ack = 1'b1;
    step(1);
    enc_ack = 1'b0;
    req_in  = 8'h00;
    chk("held_ack_valid", enc_valid, 0);
    chk("held_ack_pending", pending_out, 8'h00);

    // Single request held for 10 cycles without ack.
    req_in = 8'h20; step(1); req_in = 8'h00;
    q_hi.push_back(5);
    wait_valid(1'b0);
    for (int i = 0; i < 10; i++) step(1);
    chk("single_hold_valid", enc_valid, 1);
    chk("single_hold_idx", enc_idx, 5);
    serve(1'b0);
    chk("single_pending", pending_out, 8'h00);

    // Priority, high-first then low-first.
    req_in = 8'b0100_1001; step(1); req_in = 8'h00;
    q_hi.push_back(6); q_hi.push_back(3); q_hi.push_back(0);
    for (int i = 0; i < 3; i++) serve(1'b0);
    chk("prio_hi_pending", pending_out, 8'h00);

    req_lo = 8'b0100_1001; step(1); req_lo = 8'h00;
    q_lo.push_back(0); q_lo.push_back(3); q_lo.push_back(6);
    for (int i = 0; i < 3; i++) serve(1'b1);
    chk("prio_lo_pending", pend_lo, 8'h00);

    // Mask: bit 7 masked, bit 2 wins; masking bit 2 while valid changes nothing.
    mask_in = 8'h80;
    req_in = 8'h84; step(1); req_in = 8'h00;
    q_hi.push_back(2);
    wait_valid(1'b0);
    mask_in = 8'h84;
    step(2);
    chk("mask_hold_valid", enc_valid, 1);
    chk("mask_hold_idx", enc_idx, 2);
    enc_ack = 1'b1; step(1); enc_ack = 1'b0;
    step(2);
    chk("mask_all_valid", enc_valid, 0);
    chk("mask_all_pending", pending_out, 8'h80);
    chk("mask_all_any", any_pending, 0);
    mask_in = 8'h00;
    #1;
    chk("unmask_any", any_pending, 1);
    q_hi.push_back(7);
    serve(1'b0);

    // Collision: re-request of the in-service bit in the ack cycle.
    req_in = 8'h08; step(1); req_in = 8'h00;
    q_hi.push_back(3);
    wait_valid(1'b0);
    q_hi.push_back(3);
    enc_ack = 1'b1; req_in = 8'h08;
    step(1);
    enc_ack = 1'b0; req_in = 8'h00;
    chk("collide_pending3", pending_out[3], 1);
    chk("collide_bubble", enc_valid, 0);
    serve(1'b0);
    chk("collide_pending", pending_out, 8'h00);

    // Stray ack in IDLE.
    enc_ack = 1'b1; step(1); enc_ack = 1'b0; step(1);
    chk("stray_valid", enc_valid, 0);
    chk("stray_idx", enc_idx, 3);
    chk("stray_pending", pending_out, 8'h00);

    // Reset in the middle of a handshake.
    req_in = 8'hFF; step(1); req_in = 8'h00;
    q_hi.push_back(7);
    wait_valid(1'b0);
    chk("mid_pending", pending_out, 8'hFF);
    rst = 1'b1; enc_ack = 1'b1;
    step(1);
    chk("mid_rst_valid", enc_valid, 0);
    chk("mid_rst_pending", pending_out, 8'h00);
    chk("mid_rst_idx", enc_idx, 0);
    rst = 1'b0; enc_ack = 1'b0;
    step(3);
    chk("post_rst_valid", enc_valid, 0);

    chk("q_hi_empty", q_hi.size(), 0);
    chk("q_lo_empty", q_lo.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_irq_encoder8_3

// File: doc/irq_encoder8_3.md
Name: irq_encoder8_3

Overview:
- Sequential 8-to-3 priority encoder with request capture and a valid/ack handshake.
- Captures rising edges on 8 request lines into a pending register.
- Presents the index of the highest-priority unmasked pending request as a stable 3-bit code.
- Holds that code until the consumer acknowledges. The multi-cycle CPU control unit uses it to select interrupt/exception sources.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = bit 7 highest, 0 = bit 0 highest.
- N_REQ, 8, number of request lines. Fixed at 8; the 3-bit index width depends on it.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- req_in  input  8  request lines, level inputs, captured on rising edge
- mask_in  input  8  1 = request bit masked (ignored for selection, still captured)
- enc_ack  input  1  consumer accepts current index; meaningful only while enc_valid=1
- enc_valid  output  1  enc_idx holds a valid selection
- enc_idx  output  3  encoded index of the selected request
- pending_out  output  8  current pending register, for status reads
- any_pending  output  1  OR of (pending & ~mask_in), combinational from registers and mask

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state changes on the rising edge of clk.
- Reset values: req_q=0, pending=0, state=IDLE, enc_valid=0, enc_idx=0.
- Because req_q resets to 0, a line held high through reset is captured once after reset release.
- Edge detect: rise = req_in & ~req_q; req_q <= req_in every cycle.
- Pending update: pending <= (pending & ~clr) | rise.
  - clr is the one-hot of enc_idx when (state==VALID && enc_ack), else 0.
  - If set and clear hit the same bit in one cycle, set wins: the bit stays pending.
- FSM, two states:
  - IDLE: enc_valid=0. If (pending & ~mask_in) != 0, latch enc_idx = priority encode of (pending & ~mask_in) and go to VALID. Otherwise stay.
  - VALID: enc_valid=1; enc_idx is frozen.
    - On enc_ack=1: clear the selected pending bit, go to IDLE.
    - Without ack: stay. mask_in or pending changes never alter or retract enc_idx.
- Latency: req_in bit sampled high at edge k sets pending at edge k. enc_valid rises at edge k+1, provided the FSM is IDLE and the bit is unmasked.
- Throughput: one selection per 2 cycles; there is always a one-cycle enc_valid=0 bubble after an ack.
- enc_ack while in IDLE is ignored; no state change.
- All requests masked: FSM stays in IDLE, pending retained. Unmasking a bit makes it eligible on the next edge.
- Priority: with HIGH_FIRST=1, the highest set bit wins (e.g. 8'b1010_0000 -> 3'd7). With HIGH_FIRST=0, the lowest set bit wins.
- Re-request of the in-service bit (new rising edge while VALID): the bit stays pending after ack and is presented again.
- rst asserted mid-handshake: next edge forces the reset values above. In-flight acks are discarded.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_VALID=1'b1), N_REQ=8, IDX_W=3.
- Sub-module: reuse the existing DECODER3_8 to generate the clr one-hot from enc_idx, gated by the ack condition.
- The priority encoder stays as one function/always block inside this module.

Test Plan:
- Reset release with req_in=8'h00 -> enc_valid=0, enc_idx=0, pending_out=0; rst held 3 cycles with req_in=8'h10, then released -> pending_out=8'h10 one edge after release, enc_valid=1 with enc_idx=4 one edge later.
- Single request: pulse req_in[5] for 1 cycle, enc_ack=0 -> enc_valid=1, enc_idx=5, held for 10 cycles. Then enc_ack=1 for 1 cycle -> next cycle enc_valid=0, pending_out=0.
- Priority (HIGH_FIRST=1): req_in=8'b0100_1001 in one cycle, ack each as presented -> indices 6, 3, 0 in order, with one bubble cycle between each; repeat with HIGH_FIRST=0 -> 0, 3, 6.
- Mask: req_in[7] and req_in[2] pulse with mask_in=8'h80 -> enc_idx=2. After ack, clear the mask -> enc_idx=7. Raising mask_in[2] while idx 2 is VALID does not change enc_idx.
- Collision: while idx 3 is VALID, pulse req_in[3] low-to-high in the same cycle as enc_ack -> pending_out[3] stays 1 and idx 3 is re-presented after the bubble. Stray enc_ack in IDLE changes nothing.
- Reset mid-operation: assert rst while VALID with pending=8'hFF -> next edge enc_valid=0, pending_out=0, state IDLE.
